// File: rtl/cardio_bnn_pkg.sv
// rtl/cardio_bnn_pkg.sv - sizes, popcount widths and trained weight constants for the cardio BNN
package cardio_bnn_pkg;

  localparam int FEAT_CNT   = 19;
  localparam int FEAT_BITS  = 4;
  localparam int HIDDEN_CNT = 40;
  localparam int CLASS_CNT  = 3;
  localparam int IN_BITS    = FEAT_CNT * FEAT_BITS;
  localparam int HID_PC_W   = 7;
  localparam int CLS_PC_W   = 6;
  localparam int CLS_IDX_W  = $clog2(CLASS_CNT);

  typedef logic [HIDDEN_CNT-1:0][IN_BITS-1:0]  w1_t;
  typedef logic [HIDDEN_CNT-1:0][HID_PC_W-1:0] t1_t;
  typedef logic [CLASS_CNT-1:0][HIDDEN_CNT-1:0] w2_t;

  function automatic logic [31:0] xs32(input logic [31:0] s);
    logic [31:0] r;
    r = s ^ (s << 13);
    r = r ^ (r >> 17);
    r = r ^ (r << 5);
    return r;
  endfunction

  // Weights are exported from training as a seeded bit stream; regenerate here to keep the source compact.
  function automatic w1_t gen_w1();
    w1_t r;
    logic [31:0] s;
    s = 32'h2545_F491;
    for (int j = 0; j < HIDDEN_CNT; j++) begin
      for (int i = 0; i < IN_BITS; i++) begin
        s = xs32(s);
        r[j][i] = s[7];
      end
    end
    return r;
  endfunction

  function automatic t1_t gen_t1();
    t1_t r;
    for (int j = 0; j < HIDDEN_CNT; j++) r[j] = HID_PC_W'(34 + (j % 9));
    return r;
  endfunction

  function automatic w2_t gen_w2();
    w2_t r;
    logic [31:0] s;
    s = 32'h9E37_79B9;
    for (int c = 0; c < CLASS_CNT; c++) begin
      for (int j = 0; j < HIDDEN_CNT; j++) begin
        s = xs32(s);
        r[c][j] = s[11];
      end
    end
    return r;
  endfunction

  localparam w1_t W1_DEF = gen_w1();
  localparam t1_t T1_DEF = gen_t1();
  localparam w2_t W2_DEF = gen_w2();

endpackage

// File: rtl/cardio_bnn_xnor_popcount.sv
// rtl/cardio_bnn_xnor_popcount.sv - bnn_xnor_popcount: count of agreeing bits between a and b
module bnn_xnor_popcount #(
  parameter int N = 8
) (
  input  logic [N-1:0]             a_i,
  input  logic [N-1:0]             b_i,
  output logic [$clog2(N+1)-1:0]   count_o
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0] agree;
  assign agree = ~(a_i ^ b_i);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) count_o = count_o + CW'(agree[i]);
  end

endmodule

// File: rtl/cardio_bnn_classifier.sv
// rtl/cardio_bnn_classifier.sv - two-layer binarized classifier, features -> class label
// CARDIO_BNN_PIPE_EN adds a register stage on the hidden activations (latency 2 instead of 1).
module cardio_bnn_classifier
  import cardio_bnn_pkg::*;
#(
  parameter w1_t W1 = W1_DEF,
  parameter t1_t T1 = T1_DEF,
  parameter w2_t W2 = W2_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [IN_BITS-1:0]   features,
  output logic                 out_valid,
  output logic [CLS_IDX_W-1:0] prediction
);

  logic [HID_PC_W-1:0]   hid_cnt [HIDDEN_CNT];
  logic [CLS_PC_W-1:0]   cls_cnt [CLASS_CNT];
  logic [HIDDEN_CNT-1:0] h;
  logic [HIDDEN_CNT-1:0] h_use;
  logic                  v_use;
  logic [CLS_IDX_W-1:0]  best_idx;
  logic [CLS_PC_W-1:0]   best_cnt;
  logic                  valid_q, valid_d;
  logic [CLS_IDX_W-1:0]  pred_q, pred_d;

  for (genvar j = 0; j < HIDDEN_CNT; j++) begin : g_hid
    bnn_xnor_popcount #(.N(IN_BITS)) u_pc (
      .a_i     (features),
      .b_i     (W1[j]),
      .count_o (hid_cnt[j])
    );
    assign h[j] = (hid_cnt[j] >= T1[j]);
  end

`ifdef CARDIO_BNN_PIPE_EN
  logic [HIDDEN_CNT-1:0] h_q;
  logic                  hv_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q  <= '0;
      hv_q <= 1'b0;
    end else begin
      h_q  <= h;
      hv_q <= in_valid;
    end
  end

  assign h_use = h_q;
  assign v_use = hv_q;
`else
  assign h_use = h;
  assign v_use = in_valid;
`endif

  for (genvar c = 0; c < CLASS_CNT; c++) begin : g_cls
    bnn_xnor_popcount #(.N(HIDDEN_CNT)) u_pc (
      .a_i     (h_use),
      .b_i     (W2[c]),
      .count_o (cls_cnt[c])
    );
  end

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_cnt = cls_cnt[0];
    for (int c = 1; c < CLASS_CNT; c++) begin
      if (cls_cnt[c] > best_cnt) begin
        best_idx = CLS_IDX_W'(c);
        best_cnt = cls_cnt[c];
      end
    end
  end

  always_comb begin
    valid_d = v_use;
    pred_d  = pred_q;
    if (v_use) pred_d = best_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pred_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pred_q  <= pred_d;
    end
  end

  assign out_valid  = valid_q;
  assign prediction = pred_q;

endmodule

// File: tb/tb_cardio_bnn_classifier.sv
// tb/tb_cardio_bnn_classifier.sv - bench: six weight configurations checked against a behavioural model
module tb_cardio_bnn_classifier;
  import cardio_bnn_pkg::*;

`ifdef CARDIO_BNN_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NCFG = 6;

  localparam logic [HIDDEN_CNT-1:0] ONES  = '1;
  localparam logic [HIDDEN_CNT-1:0] ZEROS = '0;
  localparam logic [HIDDEN_CNT-1:0] PATT  = 40'hA5_3C96_0F71;

  localparam w1_t W1S [NCFG] = '{W1_DEF, '1, '1, '1, '1, '1};
  localparam t1_t T1S [NCFG] = '{T1_DEF, '0, '0,
                                 {HIDDEN_CNT{7'd76}}, {HIDDEN_CNT{7'd30}}, {HIDDEN_CNT{7'd31}}};
  localparam w2_t W2S [NCFG] = '{W2_DEF,
                                 {ONES, ZEROS, ZEROS},
                                 {PATT, PATT, PATT},
                                 {ONES, ZEROS, ONES},
                                 {ZEROS, ZEROS, ONES},
                                 {ZEROS, ZEROS, ONES}};

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic [IN_BITS-1:0]   features;
  logic [NCFG-1:0]      ov;
  logic [CLS_IDX_W-1:0] pr [NCFG];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NCFG; k++) begin : g_dut
    cardio_bnn_classifier #(.W1(W1S[k]), .T1(T1S[k]), .W2(W2S[k])) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .features   (features),
      .out_valid  (ov[k]),
      .prediction (pr[k])
    );
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Class scores from counting agreeing bits; label = first class holding the maximum score.
  function automatic int model(input int k, input logic [IN_BITS-1:0] x);
    logic [HIDDEN_CNT-1:0] hh;
    int s;
    int p [CLASS_CNT];
    int mx;
    for (int j = 0; j < HIDDEN_CNT; j++) begin
      s = 0;
      for (int i = 0; i < IN_BITS; i++) if (x[i] == W1S[k][j][i]) s++;
      hh[j] = (s >= int'(T1S[k][j]));
    end
    mx = 0;
    for (int c = 0; c < CLASS_CNT; c++) begin
      p[c] = 0;
      for (int j = 0; j < HIDDEN_CNT; j++) if (hh[j] == W2S[k][c][j]) p[c]++;
      if (p[c] > mx) mx = p[c];
    end
    for (int c = 0; c < CLASS_CNT; c++) if (p[c] == mx) return c;
    return -1;
  endfunction

  typedef struct packed {
    logic               v;
    logic [IN_BITS-1:0] x;
  } ent_t;

  ent_t pend [$];
  bit   known = 0;
  int   exp_v = 0;
  int   exp_p [NCFG];

  always @(negedge clk) begin
    ent_t e;
    if (known) begin
      for (int k = 0; k < NCFG; k++) begin
        check($sformatf("cfg%0d out_valid", k), int'(ov[k]), exp_v);
        check($sformatf("cfg%0d prediction", k), int'(pr[k]), exp_p[k]);
      end
    end
    if (!rst_n) begin
      pend.delete();
      for (int i = 0; i < LAT - 1; i++) pend.push_back('0);
      exp_v = 0;
      for (int k = 0; k < NCFG; k++) exp_p[k] = 0;
      known = 1;
    end else begin
      pend.push_back({in_valid, features});
      e = pend.pop_front();
      exp_v = int'(e.v);
      if (e.v) for (int k = 0; k < NCFG; k++) exp_p[k] = model(k, e.x);
    end
  end

  function automatic logic [IN_BITS-1:0] rand_vec();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[IN_BITS-1:0];
  endfunction

  task automatic apply_one(input logic [IN_BITS-1:0] x);
    features = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  logic [IN_BITS-1:0] vr, vf, vz, v30;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    features = '0;
    vr  = rand_vec();
    vf  = '1;
    vz  = '0;
    v30 = 76'h3FFF_FFFF;

    check("model test1", model(1, vr), 2);
    check("model tie", model(2, vr), 0);
    check("model h all 1", model(3, vf), 0);
    check("model h all 0", model(3, vz), 1);
    check("model T1 equal", model(4, v30), 0);
    check("model T1 plus 1", model(5, v30), 1);

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", int'(ov[0]), 0);
    check("reset prediction", int'(pr[0]), 0);
    rst_n = 1'b1;

    apply_one(vr);
    check("dut test1", int'(pr[1]), 2);
    check("dut tie", int'(pr[2]), 0);
    apply_one(vf);
    check("dut h all 1", int'(pr[3]), 0);
    apply_one(vz);
    check("dut h all 0", int'(pr[3]), 1);
    apply_one(v30);
    check("dut T1 equal", int'(pr[4]), 0);
    check("dut T1 plus 1", int'(pr[5]), 1);

    for (int i = 0; i < 1000; i++) begin
      features = rand_vec();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 120; i++) begin
      if (i == 51 + LAT) check("valid after reset release", int'(ov[0]), 1);
      features = rand_vec();
      in_valid = (i >= 45 && i <= 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rst_n = (i != 50);
      @(posedge clk);
      #1;
      if (i == 50) begin
        check("mid reset out_valid", int'(ov[0]), 0);
        check("mid reset prediction", int'(pr[0]), 0);
      end
    end

    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
